// File: rtl/zap_arb_pkg.sv
// Shared types for the ZAP memory arbiter: FSM states and access-size encodings.
package zap_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_IF_BUSY,
        ST_D_BUSY,
        ST_D_DRAIN
    } arb_state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/zap_mem_arbiter.sv
// Arbitrates instruction fetch and data accesses onto one memory port, one transaction at a time.
// Define ZAP_ARB_STARVE_GUARD_EN to bound consecutive data grants while a fetch waits.
module zap_mem_arbiter
    import zap_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic        o_if_valid,
    output logic [31:0] o_if_data,
    output logic        o_if_abort,
    input  logic        i_d_rd_en,
    input  logic        i_d_wr_en,
    input  logic [31:0] i_d_addr,
    input  logic [31:0] i_d_wdata,
    input  logic [1:0]  i_d_size,
    input  logic        i_d_recover,
    output logic        o_d_stall,
    output logic [31:0] o_d_rdata,
    output logic        o_d_abort,
    output logic        o_mem_req,
    output logic        o_mem_wr,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [1:0]  o_mem_size,
    input  logic        i_mem_ack,
    input  logic        i_mem_err,
    input  logic [31:0] i_mem_rdata
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("zap_mem_arbiter: STARVE_LIMIT must be in 1..15");
    end

    arb_state_t  r_state;
    logic        r_mem_req;
    logic        r_mem_wr;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [1:0]  r_mem_size;
    logic [31:0] r_d_rdata;

    logic w_d_req;
    logic w_starved;
    logic w_grant_d;
    logic w_grant_if;
    logic w_if_done;
    logic w_d_done;

    assign w_d_req = i_d_rd_en | i_d_wr_en;

`ifdef ZAP_ARB_STARVE_GUARD_EN
    logic [3:0] r_starve_cnt;

    assign w_starved = i_if_req && (r_starve_cnt >= 4'(STARVE_LIMIT));

    // Counts back-to-back data grants that overtook a waiting fetch.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_starve_cnt <= '0;
        end else if (w_grant_if) begin
            r_starve_cnt <= '0;
        end else if (w_grant_d) begin
            r_starve_cnt <= i_if_req ? r_starve_cnt + 4'd1 : '0;
        end
    end
`else
    assign w_starved = 1'b0;
`endif

    assign w_grant_d  = (r_state == ST_IDLE) && w_d_req && !w_starved;
    assign w_grant_if = (r_state == ST_IDLE) && i_if_req && !w_grant_d;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state     <= ST_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_size  <= '0;
            r_d_rdata   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_d) begin
                        r_state     <= ST_D_BUSY;
                        r_mem_req   <= 1'b1;
                        r_mem_wr    <= i_d_wr_en;
                        r_mem_addr  <= i_d_addr;
                        r_mem_wdata <= i_d_wdata;
                        r_mem_size  <= i_d_size;
                    end else if (w_grant_if) begin
                        r_state     <= ST_IF_BUSY;
                        r_mem_req   <= 1'b1;
                        r_mem_wr    <= 1'b0;
                        r_mem_addr  <= i_if_addr;
                        r_mem_wdata <= '0;
                        r_mem_size  <= SZ_WORD;
                    end
                end
                ST_IF_BUSY, ST_D_DRAIN: begin
                    if (i_mem_ack) begin
                        r_state   <= ST_IDLE;
                        r_mem_req <= 1'b0;
                    end
                end
                ST_D_BUSY: begin
                    if (i_mem_ack) begin
                        r_state   <= ST_IDLE;
                        r_mem_req <= 1'b0;
                        if (!i_d_recover) begin
                            r_d_rdata <= i_mem_rdata;
                        end
                    end else if (i_d_recover) begin
                        r_state <= ST_D_DRAIN;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign w_if_done = (r_state == ST_IF_BUSY) && i_mem_ack;
    assign w_d_done  = (r_state == ST_D_BUSY) && i_mem_ack && !i_d_recover;

    always_comb begin
        o_d_stall = 1'b0;
        case (r_state)
            ST_IDLE, ST_IF_BUSY: o_d_stall = w_d_req;
            ST_D_BUSY:           o_d_stall = w_d_req && !i_mem_ack && !i_d_recover;
            default:             o_d_stall = 1'b0;
        endcase
        o_d_stall = o_d_stall && i_reset_n;
    end

    assign o_if_valid  = w_if_done;
    assign o_if_data   = w_if_done ? i_mem_rdata : '0;
    assign o_if_abort  = w_if_done && i_mem_err;
    assign o_d_rdata   = w_d_done ? i_mem_rdata : r_d_rdata;
    assign o_d_abort   = w_d_done && i_mem_err;
    assign o_mem_req   = r_mem_req;
    assign o_mem_wr    = r_mem_wr;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_mem_size  = r_mem_size;

endmodule

// File: tb/tb_zap_mem_arbiter.sv
// Directed bench for zap_mem_arbiter: cycle-vector table plus starvation and reset sequences.
module tb_zap_mem_arbiter;

    localparam logic [31:0] A1 = 32'h0000_1000;
    localparam logic [31:0] A2 = 32'h0000_2000;
    localparam int unsigned LIMIT = 4;
    localparam int NV = 24;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic        i_if_req;
    logic [31:0] i_if_addr;
    logic        o_if_valid;
    logic [31:0] o_if_data;
    logic        o_if_abort;
    logic        i_d_rd_en;
    logic        i_d_wr_en;
    logic [31:0] i_d_addr;
    logic [31:0] i_d_wdata;
    logic [1:0]  i_d_size;
    logic        i_d_recover;
    logic        o_d_stall;
    logic [31:0] o_d_rdata;
    logic        o_d_abort;
    logic        o_mem_req;
    logic        o_mem_wr;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [1:0]  o_mem_size;
    logic        i_mem_ack;
    logic        i_mem_err;
    logic [31:0] i_mem_rdata;

    int checks = 0;
    int errors = 0;

    zap_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr),
        .o_if_valid(o_if_valid), .o_if_data(o_if_data), .o_if_abort(o_if_abort),
        .i_d_rd_en(i_d_rd_en), .i_d_wr_en(i_d_wr_en), .i_d_addr(i_d_addr),
        .i_d_wdata(i_d_wdata), .i_d_size(i_d_size), .i_d_recover(i_d_recover),
        .o_d_stall(o_d_stall), .o_d_rdata(o_d_rdata), .o_d_abort(o_d_abort),
        .o_mem_req(o_mem_req), .o_mem_wr(o_mem_wr), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_size(o_mem_size),
        .i_mem_ack(i_mem_ack), .i_mem_err(i_mem_err), .i_mem_rdata(i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic        if_req;
        logic [31:0] if_addr;
        logic        rd;
        logic        wr;
        logic [31:0] d_addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        rec;
        logic        ack;
        logic        err;
        logic [31:0] rdata;
        logic        e_req;
        logic        e_wr;
        logic [1:0]  e_size;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_ifv;
        logic        e_ifab;
        logic [31:0] e_ifd;
        logic        e_stall;
        logic        e_dab;
        logic [31:0] e_drd;
    } vec_t;

    vec_t vt [NV];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got 0x%08h expected 0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic drive_idle();
        i_if_req = 1'b0; i_d_rd_en = 1'b0; i_d_wr_en = 1'b0; i_d_addr = '0;
        i_d_wdata = '0; i_d_size = '0; i_d_recover = 1'b0;
        i_mem_ack = 1'b0; i_mem_err = 1'b0; i_mem_rdata = '0;
    endtask

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_ctl"}, 0, {24'd0, o_mem_req, o_mem_wr, o_mem_size, o_if_valid, o_if_abort, o_d_stall, o_d_abort}, '0);
        chk({name, "_bus"}, 0, o_mem_addr | o_mem_wdata | o_if_data | o_d_rdata, '0);
    endtask

    int data_n;
    int data_before;
    int fetch_n;
    bit drained;

    initial begin
        // if_req, if_addr, rd, wr, d_addr, wdata, size, rec, ack, err, rdata | req, wr, size, addr, wdata, ifv, ifab, ifd, stall, dab, drd
        vt[0]  = '{1, A1, 0, 0, 0, 0, 0, 0, 0, 0, 0,                   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[1]  = '{1, A1, 0, 0, 0, 0, 0, 0, 1, 0, 32'hE3A00001,        1, 0, 2, A1, 0, 1, 0, 32'hE3A00001, 0, 0, 0};
        vt[2]  = '{0, A1, 0, 0, 0, 0, 0, 0, 0, 0, 0,                   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[3]  = '{1, A1, 1, 0, 32'h100, 0, 2, 0, 0, 0, 0,             0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        vt[4]  = '{1, A1, 1, 0, 32'h100, 0, 2, 0, 0, 0, 0,             1, 0, 2, 32'h100, 0, 0, 0, 0, 1, 0, 0};
        vt[5]  = '{1, A1, 1, 0, 32'h100, 0, 2, 0, 1, 0, 32'h12345678,  1, 0, 2, 32'h100, 0, 0, 0, 0, 0, 0, 32'h12345678};
        vt[6]  = '{1, A1, 0, 0, 0, 0, 0, 0, 0, 0, 0,                   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h12345678};
        vt[7]  = '{1, A2, 0, 0, 0, 0, 0, 0, 1, 1, 32'hAAAA5555,        1, 0, 2, A1, 0, 1, 1, 32'hAAAA5555, 0, 0, 32'h12345678};
        vt[8]  = '{0, A2, 0, 0, 0, 0, 0, 0, 0, 0, 0,                   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h12345678};
        vt[9]  = '{0, A2, 0, 1, 32'h203, 32'hDEADBEEF, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h12345678};
        vt[10] = '{0, A2, 0, 1, 32'h203, 32'hDEADBEEF, 0, 0, 0, 0, 0,  1, 1, 0, 32'h203, 32'hDEADBEEF, 0, 0, 0, 1, 0, 32'h12345678};
        vt[11] = '{0, A2, 0, 1, 32'h203, 32'hDEADBEEF, 0, 0, 0, 0, 0,  1, 1, 0, 32'h203, 32'hDEADBEEF, 0, 0, 0, 1, 0, 32'h12345678};
        vt[12] = '{0, A2, 0, 1, 32'h203, 32'hDEADBEEF, 0, 0, 1, 0, 0,  1, 1, 0, 32'h203, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0};
        vt[13] = '{0, A2, 0, 0, 0, 0, 0, 0, 0, 0, 0,                   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[14] = '{0, A2, 1, 0, 32'h300, 0, 2, 0, 0, 0, 0,             0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        vt[15] = '{0, A2, 1, 0, 32'h300, 0, 2, 1, 0, 0, 0,             1, 0, 2, 32'h300, 0, 0, 0, 0, 0, 0, 0};
        vt[16] = '{0, A2, 0, 0, 0, 0, 0, 0, 0, 0, 0,                   1, 0, 2, 32'h300, 0, 0, 0, 0, 0, 0, 0};
        vt[17] = '{0, A2, 0, 0, 0, 0, 0, 0, 1, 1, 32'hBAD0BAD0,        1, 0, 2, 32'h300, 0, 0, 0, 0, 0, 0, 0};
        vt[18] = '{1, A2, 0, 0, 0, 0, 0, 0, 0, 0, 0,                   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[19] = '{1, A2, 0, 0, 0, 0, 0, 1, 1, 0, 32'h11112222,        1, 0, 2, A2, 0, 1, 0, 32'h11112222, 0, 0, 0};
        vt[20] = '{0, A2, 0, 0, 0, 0, 0, 0, 0, 0, 0,                   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[21] = '{0, A2, 1, 0, 32'h400, 0, 2, 0, 0, 0, 0,             0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        vt[22] = '{0, A2, 1, 0, 32'h400, 0, 2, 0, 1, 1, 32'h55,        1, 0, 2, 32'h400, 0, 0, 0, 0, 0, 1, 32'h55};
        vt[23] = '{0, A2, 0, 0, 0, 0, 0, 0, 0, 0, 0,                   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h55};

        // Reset with a pending fetch on the inputs: outputs must stay quiet.
        drive_idle();
        i_reset_n = 1'b0;
        i_if_addr = A1;
        i_if_req  = 1'b1;
        repeat (3) next_cycle();
        @(negedge i_clk);
        chk_all_zero("reset");
        next_cycle();
        i_if_req  = 1'b0;
        i_reset_n = 1'b1;
        next_cycle();

        for (int i = 0; i < NV; i++) begin
            i_if_req = vt[i].if_req;  i_if_addr = vt[i].if_addr;
            i_d_rd_en = vt[i].rd;     i_d_wr_en = vt[i].wr;
            i_d_addr = vt[i].d_addr;  i_d_wdata = vt[i].wdata;
            i_d_size = vt[i].size;    i_d_recover = vt[i].rec;
            i_mem_ack = vt[i].ack;    i_mem_err = vt[i].err;
            i_mem_rdata = vt[i].rdata;
            @(negedge i_clk);
            chk("mem_req", i, {31'd0, o_mem_req}, {31'd0, vt[i].e_req});
            if (vt[i].e_req) begin
                chk("mem_wr", i, {31'd0, o_mem_wr}, {31'd0, vt[i].e_wr});
                chk("mem_size", i, {30'd0, o_mem_size}, {30'd0, vt[i].e_size});
                chk("mem_addr", i, o_mem_addr, vt[i].e_addr);
                chk("mem_wdata", i, o_mem_wdata, vt[i].e_wdata);
            end
            chk("if_valid", i, {31'd0, o_if_valid}, {31'd0, vt[i].e_ifv});
            chk("if_abort", i, {31'd0, o_if_abort}, {31'd0, vt[i].e_ifab});
            chk("if_data", i, o_if_data, vt[i].e_ifd);
            chk("d_stall", i, {31'd0, o_d_stall}, {31'd0, vt[i].e_stall});
            chk("d_abort", i, {31'd0, o_d_abort}, {31'd0, vt[i].e_dab});
            chk("d_rdata", i, o_d_rdata, vt[i].e_drd);
            next_cycle();
        end

        // Continuous loads with a waiting fetch and a zero-wait memory.
        drive_idle();
        data_n = 0; data_before = 0; fetch_n = 0;
        for (int c = 0; c < 24; c++) begin
            i_if_req = 1'b1; i_if_addr = A2;
            i_d_rd_en = 1'b1; i_d_addr = 32'h500; i_d_size = 2'd2;
            i_mem_ack = o_mem_req;
            @(negedge i_clk);
            if (o_mem_req && i_mem_ack) begin
                if (o_mem_addr == 32'h500) begin
                    data_n++;
                    if (fetch_n == 0) data_before++;
                end else if (o_if_valid) begin
                    fetch_n++;
                end
            end
            next_cycle();
        end
        chk("starve_loads_served", 0, {31'd0, data_n > 0}, 32'd1);
`ifdef ZAP_ARB_STARVE_GUARD_EN
        chk("starve_loads_before_fetch", 0, data_before, LIMIT);
        chk("starve_fetch_served", 0, {31'd0, fetch_n > 0}, 32'd1);
`else
        chk("starve_fetch_count", 0, fetch_n, 0);
`endif

        drive_idle();
        drained = 1'b0;
        for (int c = 0; c < 10 && !drained; c++) begin
            i_mem_ack = o_mem_req;
            if (!o_mem_req) drained = 1'b1;
            next_cycle();
        end
        chk("drain_done", 0, {31'd0, drained}, 32'd1);
        drive_idle();
        next_cycle();

        // Reset in the middle of a fetch; the late ack must be ignored.
        i_if_req = 1'b1; i_if_addr = A1;
        next_cycle();
        i_if_req  = 1'b0;
        i_reset_n = 1'b0;
        @(negedge i_clk);
        chk("rst_pre_busy", 0, {31'd0, o_mem_req}, 32'd1);
        next_cycle();
        i_reset_n   = 1'b1;
        i_mem_ack   = 1'b1;
        i_mem_err   = 1'b1;
        i_mem_rdata = 32'hFFFF_FFFF;
        @(negedge i_clk);
        chk_all_zero("rst_mid");
        next_cycle();
        drive_idle();
        @(negedge i_clk);
        chk("rst_late_ifv", 0, {31'd0, o_if_valid}, 32'd0);
        chk("rst_late_req", 0, {31'd0, o_mem_req}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/zap_mem_arbiter.md
ZAP_MEM_ARBITER -- requirements
Module: zap_mem_arbiter

Interface
REQ-001 SHALL have param STARVE_LIMIT, default 4: max consecutive data grants while a fetch waits (range 1..15).
REQ-002 SHALL have port i_clk  in  1  sole clock; all state on rising edge.
REQ-003 SHALL have port i_reset_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port i_if_req  in  1  instruction fetch request.
REQ-005 SHALL have port i_if_addr  in  32  fetch address, word aligned.
REQ-006 SHALL have port o_if_valid  out  1  fetch data valid, one-cycle pulse.
REQ-007 SHALL have port o_if_data  out  32  fetched instruction.
REQ-008 SHALL have port o_if_abort  out  1  fetch fault, pulses with o_if_valid.
REQ-009 SHALL have port i_d_rd_en / i_d_wr_en  in  1 each  data load / store request.
REQ-010 SHALL have port i_d_addr, i_d_wdata  in  32 each  data address, store data.
REQ-011 SHALL have port i_d_size  in  2  0=byte, 1=halfword, 2=word.
REQ-012 SHALL have port i_d_recover  in  1  discard outstanding data access.
REQ-013 SHALL have port o_d_stall  out  1  data access not complete.
REQ-014 SHALL have port o_d_rdata  out  32 and o_d_abort  out  1  load data, data fault.
REQ-015 SHALL have port o_mem_req, o_mem_wr  out  1 each  shared-port request, write qualifier.
REQ-016 SHALL have port o_mem_addr, o_mem_wdata  out  32 each and o_mem_size  out  2.
REQ-017 SHALL have port i_mem_ack, i_mem_err  in  1 each and i_mem_rdata  in  32  completion, fault, read data.

Function
REQ-018 SHALL run FSM IDLE, IF_BUSY, D_BUSY, D_DRAIN.
REQ-019 SHALL in IDLE grant data if i_d_rd_en|i_d_wr_en, else fetch if i_if_req; next cycle o_mem_req=1 with registered addr/wdata/size/wr.
REQ-020 SHALL hold o_mem_* stable, o_mem_req=1, in *_BUSY until i_mem_ack; then drop o_mem_req and return to IDLE.
REQ-021 SHALL in IF_BUSY on ack pulse o_if_valid=1, o_if_data=i_mem_rdata, o_if_abort=i_mem_err for exactly one cycle.
REQ-022 SHALL assert o_d_stall combinationally whenever a data request is present and its ack has not arrived; deassert in the ack cycle with o_d_rdata=i_mem_rdata, o_d_abort=i_mem_err.
REQ-023 SHALL give minimum latency 2 cycles request-to-completion (grant cycle + zero-wait ack cycle).
REQ-024 SHALL force o_mem_size=2 and o_mem_wr=0 for fetches.
REQ-025 SHALL, on i_d_recover in D_BUSY, go D_DRAIN: keep o_mem_req until ack, suppress o_d_abort/o_d_rdata update, o_d_stall=0; return IDLE.
REQ-026 SHALL ignore i_d_recover in IDLE/IF_BUSY.
REQ-027 SHALL never drop a fetch request in flight; i_if_addr change during IF_BUSY takes effect only at next grant.
REQ-028 SHALL never have more than one outstanding memory transaction.

Reset
REQ-029 SHALL, while i_reset_n=0 at a clock edge, enter IDLE, clear starvation counter, drive all outputs 0.
REQ-030 SHALL abandon any in-flight access on reset; an i_mem_ack arriving after reset in IDLE is ignored.

Configuration
REQ-031 SHALL, with ZAP_ARB_STARVE_GUARD_EN defined, count consecutive data grants while i_if_req=1; at STARVE_LIMIT grant fetch next in IDLE even if data pending; counter clears on any fetch grant.
REQ-032 SHALL, without ZAP_ARB_STARVE_GUARD_EN, use fixed data priority and no counter logic.

Structure
REQ-033 SHALL place FSM state enum and size encodings (SZ_BYTE/SZ_HALF/SZ_WORD) in package zap_arb_pkg.
REQ-034 SHALL be a single module; no sub-module.

Verification
REQ-035 SHALL cover: fetch only, ack after 0 wait -> o_if_valid at cycle 2, o_if_data=0xE3A00001.
REQ-036 SHALL cover: fetch and load same cycle, addr 0x100 -> load granted first, o_d_stall high until ack, fetch granted next.
REQ-037 SHALL cover: guard on, STARVE_LIMIT=4, continuous loads plus i_if_req -> fetch granted after 4th load; guard off -> never while loads pending.
REQ-038 SHALL cover: store 0xDEADBEEF size=0 to 0x203, 3-cycle ack -> o_mem_wr=1, o_mem_size=0, addr/wdata stable 3 cycles.
REQ-039 SHALL cover: i_d_recover during D_BUSY with i_mem_err=1 at ack -> o_d_abort stays 0, FSM IDLE after ack.
REQ-040 SHALL cover: i_reset_n=0 mid IF_BUSY -> all outputs 0 next cycle, late ack produces no o_if_valid.
